// File: rtl/chan_frame_serializer_if.sv
// Bus of the channel frame serializer: frame control, parallel capture input
// and the serial output stream with its status flags.
interface chan_frame_serializer_if #(
    parameter int NCH = 22,
    parameter int DW  = 32
);
    logic              start_flag;
    logic [NCH-1:0]    ch_mask;
    logic              data_in_valid;
    logic [NCH*DW-1:0] data_in;
    logic [DW-1:0]     data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              data_out_last;
    logic              busy;
    logic              frame_done;
    logic              sample_drop;

    // Controlling side: requests frames, feeds samples and sinks the stream
    modport master (
        output start_flag, ch_mask, data_in_valid, data_in, data_out_ready,
        input  data_out, data_out_valid, data_out_last, busy, frame_done, sample_drop
    );

    // Serializer side
    modport slave (
        input  start_flag, ch_mask, data_in_valid, data_in, data_out_ready,
        output data_out, data_out_valid, data_out_last, busy, frame_done, sample_drop
    );
endinterface

// File: rtl/chan_frame_serializer.sv
// Captures one frame of CNT samples on NCH parallel channels and replays it
// channel-major over a single DW-bit valid/ready stream, skipping channels
// that are disabled in the mask latched at frame start.
module chan_frame_serializer #(
    parameter int NCH = 22,
    parameter int CNT = 1000,
    parameter int DW  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    chan_frame_serializer_if.slave bus
);
    localparam int IW = $clog2(CNT);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(CNT - 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, TRANSMIT} state_t;

    state_t         state;
    state_t         state_nxt;

    logic [DW-1:0]  mem [NCH][CNT];

    logic           start_q;
    logic [NCH-1:0] mask_q;
    logic [IW-1:0]  idx_cnt;
    logic [CW-1:0]  ch_cnt;

    logic [CW-1:0]  first_en;
    logic [CW-1:0]  last_en;
    logic [CW-1:0]  next_en;
    logic [CW-1:0]  rd_ch;

    logic           out_valid;
    logic           out_last;
    logic [DW-1:0]  out_data;
    logic           frame_done_q;
    logic           sample_drop_q;

    logic           trig;
    logic           cap_wr;
    logic           cap_done;
    logic           mask_none;
    logic           idx_end;
    logic           beat_fire;
    logic           last_fire;
    logic           issue;

    assign trig      = bus.start_flag & ~start_q;
    assign cap_wr    = (state == CAPTURE) && bus.data_in_valid;
    assign idx_end   = (idx_cnt == IDX_LAST);
    assign cap_done  = cap_wr && idx_end;
    assign mask_none = (mask_q == '0);
    assign beat_fire = out_valid && bus.data_out_ready;
    assign last_fire = beat_fire && out_last;
    // A new beat is fetched whenever the output slot is empty or being drained,
    // until the beat flagged last has been loaded.
    assign issue     = (state == TRANSMIT) && !mask_none && !out_last
                       && (!out_valid || bus.data_out_ready);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (trig) state_nxt = CAPTURE;
            CAPTURE:  if (cap_done) state_nxt = TRANSMIT;
            TRANSMIT: if (mask_none || last_fire) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output logic: status from state, stream from the output register, pulses masked by reset
    always_comb begin
        bus.busy           = (state != IDLE);
        bus.data_out       = out_data;
        bus.data_out_valid = out_valid;
        bus.data_out_last  = out_last;
        bus.frame_done     = frame_done_q & ~rst;
        bus.sample_drop    = sample_drop_q & ~rst;
    end

    // Enabled-channel search; the first fetch of a frame starts at the lowest enabled channel
    always_comb begin
        first_en = '0;
        last_en  = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask_q[k]) first_en = CW'(k);
        end
        for (int k = 0; k < NCH; k++) begin
            if (mask_q[k]) last_en = CW'(k);
        end
        rd_ch   = out_valid ? ch_cnt : first_en;
        next_en = rd_ch;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask_q[k] && (k > int'(rd_ch))) next_en = CW'(k);
        end
    end

    // Start edge detection, mask latch and the sample/channel counters
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
            mask_q  <= '0;
            idx_cnt <= '0;
            ch_cnt  <= '0;
        end else begin
            start_q <= bus.start_flag;
            if ((state == IDLE) && trig) begin
                mask_q  <= bus.ch_mask;
                idx_cnt <= '0;
                ch_cnt  <= '0;
            end else if (cap_done) begin
                idx_cnt <= '0;
                ch_cnt  <= '0;
            end else if (cap_wr) begin
                idx_cnt <= idx_cnt + 1'b1;
            end else if (issue) begin
                if (idx_end) begin
                    idx_cnt <= '0;
                    ch_cnt  <= next_en;
                end else begin
                    idx_cnt <= idx_cnt + 1'b1;
                    ch_cnt  <= rd_ch;
                end
            end
        end
    end

    // Output beat register: loaded on fetch, held while stalled, emptied after the final handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (issue) begin
            out_valid <= 1'b1;
            out_last  <= idx_end && (rd_ch == last_en);
            out_data  <= mem[rd_ch][idx_cnt];
        end else if (beat_fire) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

    // Single-cycle status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done_q  <= 1'b0;
            sample_drop_q <= 1'b0;
        end else begin
            frame_done_q  <= last_fire || (cap_done && mask_none);
            sample_drop_q <= (state == TRANSMIT) && bus.data_in_valid;
        end
    end

    // Frame storage: every channel is stored regardless of the mask
    always_ff @(posedge clk) begin
        if (cap_wr) begin
            for (int k = 0; k < NCH; k++) begin
                mem[k][idx_cnt] <= bus.data_in[(NCH - 1 - k) * DW +: DW];
            end
        end
    end
endmodule
